binary_24bitdivider: RTL and testbench

BINARY_24BITDIVIDER -- requirements
Module: binary_24bitdivider

---
 rtl/binary_24bitdivider.sv | 94 +++++++++
 tb/tb_binary_24bitdivider.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/binary_24bitdivider.sv
// rtl/binary_24bitdivider.sv - 48/24 unsigned restoring divider, one quotient bit per cycle
module binary_24bitdivider #(
    parameter int W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*W-1:0]   a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   quotient,
    output logic [W-1:0]     remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(2*W);

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

    state_t          state, state_nxt;
    logic [2*W-1:0]  dvd;
    logic [W-1:0]    dsr;
    logic [W:0]      prem;
    logic [CW-1:0]   cnt;
    logic            zero_div;
    logic [W:0]      shifted;
    logic [W:0]      diff;
    logic            fits;

    // dvd shifts dividend bits out at the top and quotient bits in at the bottom
    always_comb begin
        shifted = {prem[W-1:0], dvd[2*W-1]};
        fits    = prem[W] | (shifted >= {1'b0, dsr});
        diff    = shifted - {1'b0, dsr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nxt = (b == '0) ? FINISH : DIVIDE;
            DIVIDE:  if (cnt == '0) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd         <= '0;
            dsr         <= '0;
            prem        <= '0;
            cnt         <= '0;
            zero_div    <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd      <= a;
                        dsr      <= b;
                        prem     <= '0;
                        cnt      <= CW'(2*W-1);
                        zero_div <= (b == '0);
                    end
                end
                DIVIDE: begin
                    prem <= fits ? diff : shifted;
                    dvd  <= {dvd[2*W-2:0], fits};
                    cnt  <= cnt - CW'(1);
                end
                FINISH: begin
                    // with a zero divisor the dividend was never shifted
                    done        <= 1'b1;
                    quotient    <= zero_div ? '1 : dvd;
                    remainder   <= zero_div ? dvd[W-1:0] : prem[W-1:0];
                    div_by_zero <= zero_div;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_24bitdivider.sv
// tb/tb_binary_24bitdivider.sv - scoreboard bench for binary_24bitdivider
module tb_binary_24bitdivider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [47:0] a = '0;
    logic [23:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [47:0] quotient;
    logic [23:0] remainder;

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    int ops_expected = 0;

    typedef struct {
        logic [47:0] q;
        logic [23:0] r;
        logic        dz;
    } exp_t;
    exp_t sb[$];

    binary_24bitdivider #(.W(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", 64'(quotient), 64'(e.q));
                chk("remainder", 64'(remainder), 64'(e.r));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [47:0] av, input logic [23:0] bv,
                          input logic [47:0] eq, input logic [23:0] er, input logic edz,
                          input bit disturb);
        int n = 0;
        int bc = 0;
        exp_t e;
        e.q = eq; e.r = er; e.dz = edz;
        sb.push_back(e);
        ops_expected++;
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) bc++;
            if (done) break;
            if (n > 200) begin
                chk("done_timeout", 64'(n), 64'd49);
                break;
            end
            if (disturb) begin
                a = {$urandom, $urandom};
                b = 24'($urandom);
                start = (n == 20);
            end
            @(posedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), (bv == 0) ? 64'd1 : 64'd49);
        chk("busy_cycles", 64'(bc), (bv == 0) ? 64'd1 : 64'd49);
    endtask

    initial begin
        logic [23:0] x24, y24;
        logic [47:0] p48;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_q", 64'(quotient), 0);
        chk("rst_r", 64'(remainder), 0);
        chk("rst_dz", 64'(div_by_zero), 0);
        rst_n = 1'b1;

        run_op(48'd100, 24'd7, 48'd14, 24'd2, 1'b0, 0);
        run_op(48'hFFFF_FFFF_FFFF, 24'hFFFFFF, 48'h000001_000001, 24'd0, 1'b0, 0);
        run_op(48'hFFFF_FFFF_FFFF, 24'd1, 48'hFFFF_FFFF_FFFF, 24'd0, 1'b0, 0);
        run_op(48'h0000_0012_3456, 24'd0, 48'hFFFF_FFFF_FFFF, 24'h123456, 1'b1, 0);
        run_op(48'd9, 24'd3, 48'd3, 24'd0, 1'b0, 0);
        run_op(48'd1000, 24'd10, 48'd100, 24'd0, 1'b0, 1);
        repeat (60) @(negedge clk);

        // reset in the middle of a division
        a = 48'd12345; b = 24'd17; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 0);
        chk("async_rst_done", 64'(done), 0);
        chk("async_rst_q", 64'(quotient), 0);
        chk("async_rst_r", 64'(remainder), 0);
        chk("async_rst_dz", 64'(div_by_zero), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_op(48'd50, 24'd6, 48'd8, 24'd2, 1'b0, 0);

        for (int i = 0; i < 200; i++) begin
            x24 = 24'($urandom);
            y24 = 24'($urandom);
            if (y24 == 0) y24 = 24'd1;
            p48 = 48'(x24) * 48'(y24);
            run_op(p48, y24, 48'(x24), 24'd0, 1'b0, 0);
        end
        for (int i = 0; i < 100; i++) begin
            p48 = {16'($urandom), $urandom};
            y24 = (i % 4 == 0) ? 24'(1 + $urandom_range(0, 255)) : 24'($urandom);
            if (y24 == 0) y24 = 24'd5;
            run_op(p48, y24, p48 / 48'(y24), 24'(p48 % 48'(y24)), 1'b0, 0);
        end

        repeat (60) @(negedge clk);
        chk("done_pulses", 64'(done_count), 64'(ops_expected));
        chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
